// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Decode-stage register file with an integrated write scoreboard.
//   Register 0 reads as zero and ignores writes. Reads are combinational
//   with a same-cycle writeback bypass. Each register carries a busy bit
//   that is set when a register-writing instruction issues and cleared
//   when its writeback or cancel arrives. Issue readiness is computed
//   locally from the busy bits and the outstanding-write count.
//
// Ports
//   i_aclk          clock
//   i_reset         synchronous active-high reset
//   i_rd_addr       read address per port, port p at [p*AW +: AW]
//   i_rd_used       port p is a real source of the issuing instruction
//   o_rd_data       read data per port, port p at [p*DATA_SIZE +: DATA_SIZE]
//   o_rd_busy       addressed register still waiting for its writeback
//   i_issue_valid   instruction presented for issue
//   i_issue_wb      issuing instruction writes a register
//   i_issue_rdest   destination of the issuing instruction
//   o_issue_ready   no RAW/WAW hazard and room for another tracked write
//   i_wb            writeback valid
//   i_wb_addr       writeback register
//   i_wb_data       writeback data
//   i_cancel        squash the tracked write of a flushed instruction
//   i_cancel_addr   register whose busy bit is cancelled
//   o_busy_count    number of tracked outstanding writes
module regfile_scoreboard #(
  parameter int DATA_SIZE       = 32,
  parameter int NUM_REGS        = 32,
  parameter int NUM_RD_PORTS    = 2,
  parameter int MAX_OUTSTANDING = 8,
  localparam int AW = $clog2(NUM_REGS),
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                              i_aclk,
  input  logic                              i_reset,
  input  logic [NUM_RD_PORTS*AW-1:0]        i_rd_addr,
  input  logic [NUM_RD_PORTS-1:0]           i_rd_used,
  output logic [NUM_RD_PORTS*DATA_SIZE-1:0] o_rd_data,
  output logic [NUM_RD_PORTS-1:0]           o_rd_busy,
  input  logic                              i_issue_valid,
  input  logic                              i_issue_wb,
  input  logic [AW-1:0]                     i_issue_rdest,
  output logic                              o_issue_ready,
  input  logic                              i_wb,
  input  logic [AW-1:0]                     i_wb_addr,
  input  logic [DATA_SIZE-1:0]              i_wb_data,
  input  logic                              i_cancel,
  input  logic [AW-1:0]                     i_cancel_addr,
  output logic [CW-1:0]                     o_busy_count
);

  logic [DATA_SIZE-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]  r_busy;
  logic [CW-1:0]        r_busy_count;

  logic [AW-1:0]        w_rd_addr [NUM_RD_PORTS];
  logic                 w_wb_hit;
  logic                 w_wb_clr;
  logic                 w_cn_clr;
  logic                 w_same_clr;
  logic [1:0]           w_num_clr;
  logic                 w_src_ok;
  logic                 w_waw_ok;
  logic                 w_cap_ok;
  logic                 w_tracked;
  logic [NUM_REGS-1:0]  w_busy_nxt;

  // Writeback to register 0 is discarded entirely, so it never bypasses
  // or clears anything.
  assign w_wb_hit   = i_wb && (i_wb_addr != '0);
  assign w_wb_clr   = w_wb_hit && r_busy[i_wb_addr];
  assign w_cn_clr   = i_cancel && r_busy[i_cancel_addr];
  // wb and cancel hitting the same busy register clear only one bit.
  assign w_same_clr = w_wb_clr && w_cn_clr && (i_wb_addr == i_cancel_addr);
  assign w_num_clr  = {1'b0, w_wb_clr} + {1'b0, w_cn_clr} - {1'b0, w_same_clr};

  always_comb begin
    o_rd_data = '0;
    o_rd_busy = '0;
    w_src_ok  = 1'b1;
    for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
      w_rd_addr[p] = i_rd_addr[p*AW +: AW];
      if (w_rd_addr[p] == '0) begin
        o_rd_data[p*DATA_SIZE +: DATA_SIZE] = '0;
        o_rd_busy[p] = 1'b0;
      end else begin
        if (w_wb_hit && (i_wb_addr == w_rd_addr[p]))
          o_rd_data[p*DATA_SIZE +: DATA_SIZE] = i_wb_data;
        else
          o_rd_data[p*DATA_SIZE +: DATA_SIZE] = r_regs[w_rd_addr[p]];
        o_rd_busy[p] = r_busy[w_rd_addr[p]] &&
                       !(w_wb_hit && (i_wb_addr == w_rd_addr[p]));
      end
      if (i_rd_used[p] && o_rd_busy[p])
        w_src_ok = 1'b0;
    end
  end

  assign w_waw_ok = !(i_issue_wb && (i_issue_rdest != '0)) ||
                    !r_busy[i_issue_rdest] ||
                    (w_wb_hit && (i_wb_addr == i_issue_rdest));
  // A full scoreboard still accepts an issue when a slot frees this cycle.
  assign w_cap_ok = (r_busy_count < CW'(MAX_OUTSTANDING)) || w_wb_clr || w_cn_clr;

  assign o_issue_ready = w_src_ok && w_waw_ok && w_cap_ok;
  assign w_tracked     = i_issue_valid && o_issue_ready && i_issue_wb &&
                         (i_issue_rdest != '0);
  assign o_busy_count  = r_busy_count;

  // Clears applied before the set so a same-register issue leaves the bit on.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wb_clr)  w_busy_nxt[i_wb_addr]     = 1'b0;
    if (w_cn_clr)  w_busy_nxt[i_cancel_addr] = 1'b0;
    if (w_tracked) w_busy_nxt[i_issue_rdest] = 1'b1;
  end

  always_ff @(posedge i_aclk) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        r_regs[i] <= '0;
      r_busy       <= '0;
      r_busy_count <= '0;
    end else begin
      if (w_wb_hit)
        r_regs[i_wb_addr] <= i_wb_data;
      r_busy       <= w_busy_nxt;
      r_busy_count <= r_busy_count + CW'(w_tracked) - CW'(w_num_clr);
    end
  end

endmodule
